// File: rtl/picmicro_hw_stack.sv
// picmicro_hw_stack: parametrised return-address stack with circular or saturating overflow handling
module picmicro_hw_stack #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 8,
    parameter int MODE  = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       clr_flags,
    output logic [WIDTH-1:0]           top_data,
    output logic [$clog2(DEPTH+1)-1:0] depth_count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow_flag,
    output logic                       underflow_flag
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    sp, sp_inc, sp_dec, sp_nxt, wr_addr;
    logic [CW-1:0]    count, cnt_nxt;
    logic             wr_en, set_ov, set_un;

    assign sp_inc      = (sp == PW'(DEPTH - 1)) ? '0 : sp + PW'(1);
    assign sp_dec      = (sp == '0) ? PW'(DEPTH - 1) : sp - PW'(1);
    assign empty       = (count == '0);
    assign full        = (count == CW'(DEPTH));
    assign depth_count = count;
    assign top_data    = (MODE == 1 && empty) ? '0 : mem[sp_dec];

    // decode push/pop into a storage write, pointer/count update and flag sets
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = sp;
        sp_nxt  = sp;
        cnt_nxt = count;
        set_ov  = 1'b0;
        set_un  = 1'b0;
        if (push && pop && !empty) begin
            wr_en   = 1'b1;
            wr_addr = sp_dec;
        end else if (push) begin
            set_un = pop;
            set_ov = full;
            if (!full || MODE == 0) begin
                wr_en   = 1'b1;
                sp_nxt  = sp_inc;
                cnt_nxt = full ? count : count + CW'(1);
            end
        end else if (pop) begin
            set_un  = empty;
            sp_nxt  = (!empty || MODE == 0) ? sp_dec : sp;
            cnt_nxt = empty ? count : count - CW'(1);
        end
    end

    // register pointer, count, sticky flags and storage; reset clears all entries
    always_ff @(posedge clk) begin
        if (!rst) begin
            sp             <= '0;
            count          <= '0;
            overflow_flag  <= 1'b0;
            underflow_flag <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            sp             <= sp_nxt;
            count          <= cnt_nxt;
            overflow_flag  <= set_ov | (overflow_flag & ~clr_flags);
            underflow_flag <= set_un | (underflow_flag & ~clr_flags);
            if (wr_en) mem[wr_addr] <= push_data;
        end
    end
endmodule

// File: tb/tb_picmicro_hw_stack.sv
// tb_picmicro_hw_stack: checks circular and saturating stacks against an ordered-list model
module tb_picmicro_hw_stack;
    logic        clk = 1'b0;
    logic        rst, push, pop, clr_flags;
    logic [12:0] push_data;
    logic [12:0] top [2];
    logic [3:0]  dc [2];
    logic        emp [2], ful [2], ovf [2], unf [2];
    int          cmp = 0, err = 0;
    bit          started = 1'b0;

    // model: list ordered oldest..newest, plus sticky flags, per mode
    logic [12:0] mq [2][8];
    int          mn [2];
    logic        mo [2], mu [2];

    always #5 clk = ~clk;

    picmicro_hw_stack #(.WIDTH(13), .DEPTH(8), .MODE(0)) u0 (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data), .clr_flags(clr_flags),
        .top_data(top[0]), .depth_count(dc[0]), .empty(emp[0]), .full(ful[0]),
        .overflow_flag(ovf[0]), .underflow_flag(unf[0]));

    picmicro_hw_stack #(.WIDTH(13), .DEPTH(8), .MODE(1)) u1 (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data), .clr_flags(clr_flags),
        .top_data(top[1]), .depth_count(dc[1]), .empty(emp[1]), .full(ful[1]),
        .overflow_flag(ovf[1]), .underflow_flag(unf[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // advance the model on each edge from the inputs it sees
    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            logic so, su;
            so = 1'b0;
            su = 1'b0;
            if (!rst) begin
                mn[m] = 0;
                mo[m] = 1'b0;
                mu[m] = 1'b0;
            end else begin
                if (push && pop && mn[m] > 0) mq[m][mn[m]-1] = push_data;
                else if (push) begin
                    su = pop;
                    if (mn[m] < 8) begin
                        mq[m][mn[m]] = push_data;
                        mn[m]++;
                    end else begin
                        so = 1'b1;
                        if (m == 0) begin
                            for (int k = 0; k < 7; k++) mq[m][k] = mq[m][k+1];
                            mq[m][7] = push_data;
                        end
                    end
                end else if (pop) begin
                    if (mn[m] > 0) mn[m]--;
                    else su = 1'b1;
                end
                mo[m] = so | (mo[m] & ~clr_flags);
                mu[m] = su | (mu[m] & ~clr_flags);
            end
        end
    end

    // compare both instances against the model away from the active edge
    always @(negedge clk) begin
        if (started) begin
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("m%0d depth", m), 32'(dc[m]), 32'(mn[m]));
                chk($sformatf("m%0d empty", m), 32'(emp[m]), 32'(mn[m] == 0));
                chk($sformatf("m%0d full", m), 32'(ful[m]), 32'(mn[m] == 8));
                chk($sformatf("m%0d ovf", m), 32'(ovf[m]), 32'(mo[m]));
                chk($sformatf("m%0d unf", m), 32'(unf[m]), 32'(mu[m]));
                if (m == 1 || mn[m] > 0)
                    chk($sformatf("m%0d top", m), 32'(top[m]), mn[m] > 0 ? 32'(mq[m][mn[m]-1]) : 32'h0);
            end
        end
    end

    task automatic step(input logic r, input logic p, input logic o, input logic [12:0] d, input logic c);
        rst       = r;
        push      = p;
        pop       = o;
        push_data = d;
        clr_flags = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        step(1'b0, 1'b1, 1'b0, 13'h1FF, 1'b0);
        started = 1'b1;
        step(1'b0, 1'b1, 1'b0, 13'h1FF, 1'b0);
        step(1'b1, 1'b0, 1'b0, 13'h0, 1'b0);
        for (int m = 0; m < 2; m++) begin
            chk("rst depth", 32'(dc[m]), 32'd0);
            chk("rst empty", 32'(emp[m]), 32'd1);
            chk("rst full", 32'(ful[m]), 32'd0);
            chk("rst top", 32'(top[m]), 32'd0);
            chk("rst flags", 32'({ovf[m], unf[m]}), 32'd0);
        end
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 13'(32'h100 + i), 1'b0);
        for (int m = 0; m < 2; m++) begin
            chk("fill full", 32'(ful[m]), 32'd1);
            chk("fill depth", 32'(dc[m]), 32'd8);
            chk("fill top", 32'(top[m]), 32'h107);
        end
        for (int i = 0; i < 8; i++) begin
            chk("drain top m0", 32'(top[0]), 32'h107 - i);
            chk("drain top m1", 32'(top[1]), 32'h107 - i);
            step(1'b1, 1'b0, 1'b1, 13'h0, 1'b0);
        end
        for (int m = 0; m < 2; m++) begin
            chk("drain empty", 32'(emp[m]), 32'd1);
            chk("drain flags", 32'({ovf[m], unf[m]}), 32'd0);
        end
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 13'(32'h100 + i), 1'b0);
        step(1'b1, 1'b1, 1'b0, 13'h1AA, 1'b0);
        chk("ovf m0 flag", 32'(ovf[0]), 32'd1);
        chk("ovf m1 flag", 32'(ovf[1]), 32'd1);
        chk("ovf m0 depth", 32'(dc[0]), 32'd8);
        chk("ovf m1 depth", 32'(dc[1]), 32'd8);
        chk("ovf m0 top", 32'(top[0]), 32'h1AA);
        chk("ovf m1 top", 32'(top[1]), 32'h107);
        for (int i = 0; i < 8; i++) begin
            chk("wrap top m0", 32'(top[0]), i == 0 ? 32'h1AA : 32'h108 - i);
            chk("sat top m1", 32'(top[1]), 32'h107 - i);
            step(1'b1, 1'b0, 1'b1, 13'h0, 1'b0);
        end
        step(1'b1, 1'b0, 1'b0, 13'h0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 13'h0, 1'b0);
        for (int m = 0; m < 2; m++) begin
            chk("unf set", 32'(unf[m]), 32'd1);
            chk("unf depth", 32'(dc[m]), 32'd0);
        end
        step(1'b1, 1'b0, 1'b0, 13'h0, 1'b1);
        chk("clr alone", 32'(unf[0]), 32'd0);
        step(1'b1, 1'b0, 1'b1, 13'h0, 1'b1);
        chk("set beats clr", 32'(unf[1]), 32'd1);
        step(1'b1, 1'b0, 1'b0, 13'h0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 13'h011, 1'b0);
        step(1'b1, 1'b1, 1'b0, 13'h022, 1'b0);
        step(1'b1, 1'b1, 1'b0, 13'h055, 1'b0);
        step(1'b1, 1'b1, 1'b1, 13'h0AA, 1'b0);
        for (int m = 0; m < 2; m++) begin
            chk("replace top", 32'(top[m]), 32'h0AA);
            chk("replace depth", 32'(dc[m]), 32'd3);
        end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 13'h0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 13'h033, 1'b0);
        for (int m = 0; m < 2; m++) begin
            chk("pp empty depth", 32'(dc[m]), 32'd1);
            chk("pp empty top", 32'(top[m]), 32'h033);
            chk("pp empty unf", 32'(unf[m]), 32'd1);
        end
        step(1'b1, 1'b1, 1'b0, 13'h044, 1'b0);
        step(1'b0, 1'b1, 1'b1, 13'h077, 1'b0);
        chk("mid rst depth", 32'(dc[0]), 32'd0);
        chk("mid rst flags", 32'({ovf[1], unf[1]}), 32'd0);
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            step(r != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                 13'($urandom), $urandom_range(0, 9) == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule

// File: doc/picmicro_hw_stack.md
Name: picmicro_hw_stack

Overview:
Parametrised hardware return-address stack for the midrange core family, used by CALL/RETURN/RETFIE/RETLW sequencing in the instruction decoder. It is generalised in width, depth and overflow mode. Mode 0 reproduces the circular midrange stack. Mode 1 adds saturating, enhanced-style behaviour with sticky overflow/underflow flags. It sits beside program_counter: push_data comes from PC+1 and top_data feeds the PC load path on return.

Parameters:
WIDTH, 13, bits per entry (program counter width)
DEPTH, 8, number of entries; any value >= 2, not restricted to powers of two
MODE, 0, 0 = circular wrap on overflow/underflow; 1 = saturating, the offending op is dropped

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-low (sampled on clk rising edge; 0 = reset)
push  input  1  push push_data this cycle
pop  input  1  pop top entry this cycle
push_data  input  WIDTH  value to push
clr_flags  input  1  clear sticky overflow/underflow flags
top_data  output  WIDTH  current top-of-stack value
depth_count  output  $clog2(DEPTH+1)  number of valid entries, 0..DEPTH
empty  output  1  depth_count == 0
full  output  1  depth_count == DEPTH
overflow_flag  output  1  sticky: push attempted while full
underflow_flag  output  1  sticky: pop attempted while empty

Behaviour:
- State: storage array mem[0..DEPTH-1]; sp = index of next free slot (0..DEPTH-1, wraps DEPTH-1 -> 0 by compare, no modulo operator); count; two sticky flags.
- Reset (rst == 0 at a clk edge): sp = 0, count = 0, both flags = 0, and every mem entry = 0. After reset: top_data = 0, depth_count = 0, empty = 1, full = 0.
- top_data = mem[sp-1, wrapped] combinationally from registered state, so there is zero latency after the edge that updates sp.
  - Mode 1 with count == 0: top_data is forced to 0.
  - Mode 0: top_data always shows mem[sp-1], even when empty.
- All updates happen on the clk rising edge; push and pop are single-cycle with no handshake. Ops take effect one edge later.
- Push only:
  - If count < DEPTH: mem[sp] <= push_data; sp++; count++.
  - If count == DEPTH: overflow_flag <= 1 in both modes.
    - Mode 0: write mem[sp], sp++; count stays DEPTH. The oldest entry is overwritten.
    - Mode 1: no write; sp and count are unchanged.
- Pop only:
  - If count > 0: sp--; count--. Storage is not cleared.
  - If count == 0: underflow_flag <= 1.
    - Mode 0: sp-- (wraps 0 -> DEPTH-1); count stays 0.
    - Mode 1: no change.
- Push and pop in the same cycle:
  - count > 0: replace top. mem[sp-1] <= push_data; sp and count are unchanged; no flags are set, even when full.
  - count == 0: underflow_flag <= 1, then the op behaves as push only (count becomes 1). This is the same in both modes.
- clr_flags: clears both flags on the next edge. If the same edge also sets a flag, the set wins.
- Reset asserted mid-sequence (together with push/pop) overrides everything.
- No combinational path from push, pop or push_data to any output.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with push=1 -> depth_count=0, empty=1, full=0, top_data=0, both flags 0.
2. DEPTH=8: push 0x100..0x107 on consecutive cycles -> full=1, depth_count=8, top_data=0x107. Then 8 pops -> top_data before each pop reads 0x107,0x106,...,0x100; afterwards empty=1 and no flags set.
3. MODE=0 overflow: push 0x100..0x107, then push 0x1AA -> overflow_flag=1, depth_count=8, top_data=0x1AA. Then 8 pops -> top_data sequence 0x1AA,0x107,0x106,...,0x101.
4. MODE=1 overflow: push 0x100..0x107, then push 0x1AA -> overflow_flag=1, depth_count=8, top_data=0x107 (0x1AA dropped).
5. Underflow and flag clear: pop when empty -> underflow_flag=1, depth_count=0. clr_flags=1 alone -> flag 0. clr_flags=1 plus pop when empty on the same edge -> flag stays 1.
6. Simultaneous ops: with entries 0x011,0x022,0x055 (top 0x055), push=pop=1 with push_data=0x0AA -> top_data=0x0AA, depth_count=3. With the stack empty, push=pop=1 with push_data=0x033 -> depth_count=1, top_data=0x033, underflow_flag=1.
